// File: rtl/copyread_req_queue.sv
// Per-lane FWFT request FIFOs feeding the 16-way copy-read selector.
// Head entry and valid are registered state only; grants pop the lane.
module copyread_req_queue #(
  parameter int NUM_LANES    = 16,
  parameter int ENTRY_W      = 81,
  parameter int DEPTH        = 4,
  parameter int PTR_W        = 2,
  parameter int AFULL_MARGIN = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clear,
  input  logic [NUM_LANES*ENTRY_W-1:0]   req_in,
  input  logic [NUM_LANES-1:0]           req_push,
  output logic [NUM_LANES-1:0]           req_afull,
  input  logic [NUM_LANES-1:0]           rd_in,
  output logic [NUM_LANES*ENTRY_W-1:0]   data_out,
  output logic [NUM_LANES-1:0]           data_valid,
  output logic [NUM_LANES-1:0]           overflow,
  output logic                           idle
);

  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_C = CNT_W'(AFULL_MARGIN);

  logic [ENTRY_W-1:0] mem_q [NUM_LANES][DEPTH];
  logic [CNT_W-1:0]   count_q  [NUM_LANES];
  logic [CNT_W-1:0]   count_d  [NUM_LANES];
  logic [PTR_W-1:0]   rd_ptr_q [NUM_LANES];
  logic [PTR_W-1:0]   rd_ptr_d [NUM_LANES];
  logic [PTR_W-1:0]   wr_ptr_q [NUM_LANES];
  logic [PTR_W-1:0]   wr_ptr_d [NUM_LANES];
  logic [NUM_LANES-1:0] overflow_q, overflow_d;
  logic [NUM_LANES-1:0] pop, push_ok, full;

  always_comb begin
    data_valid = '0;
    req_afull  = '0;
    data_out   = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      data_valid[i] = (count_q[i] != '0);
      req_afull[i]  = (DEPTH_C - count_q[i]) <= AFULL_C;
      data_out[i*ENTRY_W +: ENTRY_W] = mem_q[i][rd_ptr_q[i]];
    end
  end

  assign overflow = overflow_q;
  assign idle     = ~|data_valid;

  // A pop frees a slot in the same cycle, so a full lane still accepts a push
  always_comb begin
    pop     = '0;
    full    = '0;
    push_ok = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      pop[i]     = rd_in[i] & data_valid[i];
      full[i]    = (count_q[i] == DEPTH_C);
      push_ok[i] = req_push[i] & (~full[i] | pop[i]);
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      count_d[i]  = count_q[i];
      rd_ptr_d[i] = rd_ptr_q[i];
      wr_ptr_d[i] = wr_ptr_q[i];
      if (push_ok[i])
        wr_ptr_d[i] = wr_ptr_q[i] + 1'b1;
      if (pop[i])
        rd_ptr_d[i] = rd_ptr_q[i] + 1'b1;
      if (push_ok[i] & ~pop[i])
        count_d[i] = count_q[i] + 1'b1;
      else if (pop[i] & ~push_ok[i])
        count_d[i] = count_q[i] - 1'b1;
      if (clear) begin
        count_d[i]  = '0;
        rd_ptr_d[i] = '0;
        wr_ptr_d[i] = '0;
      end
    end
    overflow_d = clear ? '0 : (overflow_q | (req_push & ~push_ok));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        count_q[i]  <= '0;
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
      end
      overflow_q <= '0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        count_q[i]  <= count_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        wr_ptr_q[i] <= wr_ptr_d[i];
      end
      overflow_q <= overflow_d;
    end
  end

  // Storage is deliberately left unreset; data_out is ignored while invalid
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LANES; i++) begin
      if (push_ok[i] && !clear)
        mem_q[i][wr_ptr_q[i]] <= req_in[i*ENTRY_W +: ENTRY_W];
    end
  end

endmodule

// File: tb/tb_copyread_req_queue.sv
// Randomized bench for copyread_req_queue against a per-lane queue model.
// Directed phases cover fill/overflow, full push+pop, spurious grant, clear, reset.
module tb_copyread_req_queue;

  localparam int NL = 16;
  localparam int EW = 81;
  localparam int DP = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clear = 1'b0;
  logic [NL*EW-1:0]  req_in = '0;
  logic [NL-1:0]     req_push = '0;
  logic [NL-1:0]     req_afull;
  logic [NL-1:0]     rd_in = '0;
  logic [NL*EW-1:0]  data_out;
  logic [NL-1:0]     data_valid;
  logic [NL-1:0]     overflow;
  logic              idle;

  int checks = 0;
  int failures = 0;

  logic [EW-1:0] mq [NL][$];
  logic [NL-1:0] movf = '0;

  copyread_req_queue dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .req_in     (req_in),
    .req_push   (req_push),
    .req_afull  (req_afull),
    .rd_in      (rd_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .overflow   (overflow),
    .idle       (idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [EW-1:0] got,
                     input logic [EW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    bit all_empty = 1'b1;
    for (int i = 0; i < NL; i++) begin
      int sz = mq[i].size();
      if (sz != 0) all_empty = 1'b0;
      chk($sformatf("valid%0d", i), EW'(data_valid[i]), EW'(sz != 0));
      if (sz != 0)
        chk($sformatf("head%0d", i), data_out[i*EW +: EW], mq[i][0]);
      chk($sformatf("afull%0d", i), EW'(req_afull[i]), EW'((DP - sz) <= 1));
      chk($sformatf("ovf%0d", i), EW'(overflow[i]), EW'(movf[i]));
    end
    chk("idle", EW'(idle), EW'(all_empty));
  endtask

  task automatic model_reset();
    for (int i = 0; i < NL; i++) mq[i].delete();
    movf = '0;
  endtask

  // Drive one cycle of stimulus, then advance the model on the clock edge
  task automatic step(input logic [NL-1:0] p, input logic [NL-1:0] r,
                      input logic c);
    logic [95:0] rnd;
    logic [EW-1:0] ent [NL];
    @(negedge clk);
    check_outputs();
    for (int i = 0; i < NL; i++) begin
      rnd = {$urandom, $urandom, $urandom};
      ent[i] = rnd[EW-1:0];
      req_in[i*EW +: EW] = ent[i];
    end
    req_push = p;
    rd_in    = r;
    clear    = c;
    @(posedge clk);
    if (c) begin
      model_reset();
    end else begin
      for (int i = 0; i < NL; i++) begin
        bit pp = r[i] && mq[i].size() != 0;
        bit fl = mq[i].size() == DP;
        if (pp) void'(mq[i].pop_front());
        if (p[i]) begin
          if (!fl || pp) mq[i].push_back(ent[i]);
          else movf[i] = 1'b1;
        end
      end
    end
  endtask

  initial begin
    logic [NL-1:0] p, r;
    model_reset();
    #12;
    check_outputs();
    rst_n = 1'b1;

    // Lane 2: fill to full, then one dropped push
    for (int k = 0; k < 5; k++) step(16'h0004, '0, 1'b0);
    for (int k = 0; k < 5; k++) step('0, 16'h0004, 1'b0);

    // Lane 7: fill, then push while granted at full
    for (int k = 0; k < 4; k++) step(16'h0080, '0, 1'b0);
    step(16'h0080, 16'h0080, 1'b0);
    for (int k = 0; k < 5; k++) step('0, 16'h0080, 1'b0);

    // Spurious grant on empty lane 8, then a real push
    step('0, 16'h0100, 1'b0);
    step(16'h0100, 16'h0100, 1'b0);
    step('0, 16'h0100, 1'b0);

    // Lane 5 streaming push with grant each cycle
    step(16'h0020, '0, 1'b0);
    for (int k = 0; k < 9; k++) step(16'h0020, 16'h0020, 1'b0);
    step('0, 16'h0020, 1'b0);

    // Random traffic with occasional clear and multi-hot grant
    for (int k = 0; k < 1500; k++) begin
      case ($urandom_range(0, 3))
        0: p = NL'($urandom);
        1: p = NL'($urandom & $urandom & $urandom);
        default: p = NL'($urandom & $urandom);
      endcase
      case ($urandom_range(0, 9))
        0: r = '0;
        1: r = NL'($urandom);
        default: r = NL'(1) << $urandom_range(0, NL - 1);
      endcase
      step(p, r, $urandom_range(0, 150) == 0);
    end

    // Clear with pushes on lanes 0 and 15 in the same cycle
    for (int k = 0; k < 3; k++) step(16'hFFFF, '0, 1'b0);
    step(16'h8001, '0, 1'b1);
    step('0, '0, 1'b0);

    // Reset mid-traffic: lanes 0-3 hold two entries
    step(16'h000F, '0, 1'b0);
    step(16'h000F, '0, 1'b0);
    @(negedge clk);
    check_outputs();
    req_push = '0;
    rd_in    = '0;
    rst_n    = 1'b0;
    #1;
    chk("rst_valid", EW'(data_valid), '0);
    chk("rst_idle", EW'(idle), EW'(1));
    chk("rst_ovf", EW'(overflow), '0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(16'h0001, '0, 1'b0);
    step('0, 16'h0001, 1'b0);
    step('0, '0, 1'b0);

    @(negedge clk);
    check_outputs();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
